// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word aliases and sequencer state.
// Imported by the pipeline control blocks.
package cpu_types_pkg;

  localparam int REG_BITS  = 5;
  localparam int WORD_BITS = 32;

  typedef logic [REG_BITS-1:0]  regbit_t;
  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } seq_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } seq_ctl_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Sequencer <-> datapath bundle.
// seq drives latch controls, dp drives hazard sources.
interface pipeline_sequencer_if
  import cpu_types_pkg::*;
();

  logic    ihit;
  logic    dhit;
  logic    mem_dREN;
  logic    mem_dWEN;
  logic    ex_dREN;
  regbit_t ex_regDst;
  regbit_t id_rs;
  regbit_t id_rt;
  logic    ex_pcsrc;
  logic    id_halt;
  logic    pc_en;
  logic    ifid_en;
  logic    idex_en;
  logic    exmem_en;
  logic    memwb_en;
  logic    ifid_flush;
  logic    idex_flush;
  logic    exmem_flush;
  logic    memwb_flush;
  logic    halt;

  modport seq (
    input  ihit, dhit, mem_dREN, mem_dWEN,
    input  ex_dREN, ex_regDst, id_rs, id_rt,
    input  ex_pcsrc, id_halt,
    output pc_en, ifid_en, idex_en,
    output exmem_en, memwb_en,
    output ifid_flush, idex_flush,
    output exmem_flush, memwb_flush,
    output halt
  );

  modport dp (
    output ihit, dhit, mem_dREN, mem_dWEN,
    output ex_dREN, ex_regDst, id_rs, id_rt,
    output ex_pcsrc, id_halt,
    input  pc_en, ifid_en, idex_en,
    input  exmem_en, memwb_en,
    input  ifid_flush, idex_flush,
    input  exmem_flush, memwb_flush,
    input  halt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between EX load and ID sources.
// Shared with the forwarding unit.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_regDst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             lu
);

  // r0 is hardwired zero, so a load into it never blocks
  assign lu = ex_dREN
            & (ex_regDst != '0)
            & ((ex_regDst == id_rs)
             | (ex_regDst == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller with halt drain FSM
// and stall/flush performance counters.
module pipeline_sequencer
  import cpu_types_pkg::*;
#(
  parameter int DRAIN_ADV = 3,
  parameter int CNT_W     = 32,
  parameter int REG_W     = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_regDst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_pcsrc,
  input  logic             id_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN_ADV + 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] drain_nxt;
  seq_ctl_t      ctl;
  logic          dstall;
  logic          lu;
  logic          stall_inc;
  logic          flush_inc;

  hazard_detect #(.REG_W(REG_W)) u_hz (
    .ex_dREN   (ex_dREN),
    .ex_regDst (ex_regDst),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .lu        (lu)
  );

  assign dstall = (mem_dREN | mem_dWEN) & ~dhit;

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    drain_nxt = drain_cnt;
    flush_inc = 1'b0;
    case (state)
      RUN: begin
        if (dstall) begin
          ctl.memwb_en    = 1'b1;
          ctl.memwb_flush = 1'b1;
        end else if (ex_pcsrc) begin
          ctl            = '1;
          ctl.exmem_flush = 1'b0;
          ctl.memwb_flush = 1'b0;
          flush_inc      = 1'b1;
        end else if (lu) begin
          ctl.idex_en    = 1'b1;
          ctl.idex_flush = 1'b1;
          ctl.exmem_en   = 1'b1;
          ctl.memwb_en   = 1'b1;
        end else begin
          ctl.pc_en      = ihit;
          ctl.ifid_en    = 1'b1;
          ctl.ifid_flush = ~ihit;
          ctl.idex_en    = 1'b1;
          ctl.exmem_en   = 1'b1;
          ctl.memwb_en   = 1'b1;
        end
        // HALT only counts once it cleanly enters EX
        if (id_halt && ctl.idex_en && !ctl.idex_flush
            && !dstall && !ex_pcsrc) begin
          state_nxt = DRAIN;
          drain_nxt = DW'(DRAIN_ADV);
        end
      end
      DRAIN: begin
        ctl.ifid_en    = 1'b1;
        ctl.ifid_flush = 1'b1;
        ctl.memwb_en   = 1'b1;
        if (dstall) begin
          ctl.memwb_flush = 1'b1;
        end else begin
          ctl.idex_en  = 1'b1;
          ctl.exmem_en = 1'b1;
        end
        if (ctl.exmem_en) begin
          if (drain_cnt == DW'(1)) begin
            state_nxt = HALTED;
          end
          drain_nxt = drain_cnt - DW'(1);
        end
      end
      default: begin
        ctl = '0;
      end
    endcase
    if (!nRST) begin
      ctl = '0;
    end
  end

  assign stall_inc = (state == RUN) & ~ctl.pc_en & nRST;

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign idex_en     = ctl.idex_en;
  assign exmem_en    = ctl.exmem_en;
  assign memwb_en    = ctl.memwb_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_flush = ctl.memwb_flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= '0;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      halt      <= (state_nxt == HALTED);
      stall_cnt <= stall_cnt + CNT_W'(stall_inc);
      flush_cnt <= flush_cnt + CNT_W'(flush_inc);
    end
  end

endmodule
